// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Start/busy/done handshake and operand/result bus for the
//               bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor, Diff = A - B - Bin, LSB
//               first, one bit per clock through a single full-subtractor cell.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_diff_sh;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_busy;
    logic               r_done;

    logic               w_a0;
    logic               w_b0;
    logic               w_d;
    logic               w_br_nxt;
    logic [WIDTH-1:0]   w_diff_nxt;

    // Full-subtractor cell on the current LSB of the operand shift registers.
    assign w_a0     = r_a_sh[0];
    assign w_b0     = r_b_sh[0];
    assign w_d      = w_a0 ^ w_b0 ^ r_br;
    assign w_br_nxt = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);

    // New bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
    assign w_diff_nxt = (r_diff_sh >> 1) | {w_d, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff_sh <= '0;
            r_br      <= 1'b0;
            r_cnt     <= '0;
            r_diff    <= '0;
            r_bout    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sh    <= bus.A;
                        r_b_sh    <= bus.B;
                        r_br      <= bus.Bin;
                        r_diff_sh <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_diff_sh <= w_diff_nxt;
                    r_br      <= w_br_nxt;
                    r_cnt     <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_diff  <= w_diff_nxt;
                        r_bout  <= w_br_nxt;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.Diff = r_diff;
    assign bus.Bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Randomized scoreboard bench for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W:0] res;
        int         dcyc;
    } exp_t;

    exp_t       q[$];
    int         cyc        = 0;
    int         next_ok    = 0;
    int         busy_until = -1;
    logic [W:0] last_res   = '0;
    int         total      = 0;
    int         bad        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        next_ok    = 0;
        busy_until = -1;
        last_res   = '0;
    endfunction

    // Reference model: one op every W+2 edges, result from plain arithmetic.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else if (bus.start && cyc >= next_ok) begin
            exp_t e;
            e.res      = {1'b0, bus.A} - {1'b0, bus.B} - (W+1)'(bus.Bin);
            e.dcyc     = cyc + W;
            q.push_back(e);
            busy_until = cyc + W;
            next_ok    = cyc + W + 2;
        end
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (rst) begin
            model_reset();
            check("rst_busy", 32'(bus.busy), 0);
            check("rst_done", 32'(bus.done), 0);
            check("rst_result", 32'({bus.Bout, bus.Diff}), 0);
        end else begin
            logic exp_done;
            exp_done = (q.size() > 0) && (q[0].dcyc == cyc);
            check("busy", 32'(bus.busy), 32'(cyc <= busy_until));
            check("done", 32'(bus.done), 32'(exp_done));
            if (exp_done) begin
                last_res = q[0].res;
                void'(q.pop_front());
                check("result", 32'({bus.Bout, bus.Diff}), 32'(last_res));
            end else begin
                check("hold", 32'({bus.Bout, bus.Diff}), 32'(last_res));
            end
        end
    end

    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(posedge clk);
        #2;
        bus.start = s;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 40);
        check("done_timeout", 32'(n < 40), 1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        drive(1'b1, a, b, bin);
        drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
        wait_done();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        op(8'h05, 8'h03, 1'b0);
        op(8'h03, 8'h05, 1'b0);
        op(8'h80, 8'h01, 1'b0);
        op(8'h00, 8'h00, 1'b1);
        op(8'hFF, 8'hFF, 1'b0);
        op(8'h00, 8'hFF, 1'b1);

        // Continuous start with operands changing every cycle.
        for (int i = 0; i < 60; i++)
            drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        drive(1'b0, '0, '0, 1'b0);
        repeat (12) @(posedge clk);

        // Reset in the middle of a run.
        drive(1'b1, 8'h5A, 8'h21, 1'b1);
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (12) @(negedge clk);
        op(8'h10, 8'h01, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
